// File: rtl/cpu_io_responder_if.sv
// CPU data-port and TX/RX stream signals of the CPU I/O responder.
// slave: the responder side; master: the CPU plus the stream endpoints.
interface cpu_io_responder_if;
   logic [31:0] addr;
   logic        w_req;
   logic [31:0] w_data;
   logic        w_busy;
   logic        irr;
   logic        ack;
   logic [31:0] r_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;

   modport slave (
      input  addr, w_req, w_data, ack, tx_ready, rx_valid, rx_data,
      output w_busy, irr, r_data, tx_valid, tx_data, rx_ready
   );

   modport master (
      output addr, w_req, w_data, ack, tx_ready, rx_valid, rx_data,
      input  w_busy, irr, r_data, tx_valid, tx_data, rx_ready
   );
endinterface

// File: rtl/cpu_io_responder.sv
// Bus-side responder for the multicycle CPU: TX byte FIFO, single-byte RX holding register with irr.
// Optional macro CPU_IO_STATUS_EN enables the STATUS read at offset 0x8.
module cpu_io_responder #(
   parameter logic [15:0] BASE_ADDR  = 16'hFFFF,
   parameter int          FIFO_DEPTH = 4,
   parameter int          PERIOD     = 3
) (
   input logic                 clk,
   input logic                 reset,
   cpu_io_responder_if.slave   bus
);
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [PW-1:0] phase_q, phase_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          rx_full_q, rx_full_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          w_busy_q, irr_q;
   logic [31:0]   r_data_q, r_data_d;

   logic          sample, hit, push, pop, rx_cap, rx_clr;
   logic [15:0]   offset;
   logic          unused_w_data;

   assign unused_w_data = ^bus.w_data[31:8];

   always_comb begin
      phase_d   = (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + PW'(1);
      // Everything CPU-facing happens once per instruction, at the end of phase 0.
      sample    = (phase_q == '0);
      hit       = (bus.addr[31:16] == BASE_ADDR);
      offset    = bus.addr[15:0];
      push      = sample && bus.w_req && hit && (offset == 16'h0000) && !w_busy_q;
      pop       = (count_q != '0) && bus.tx_ready;
      count_d   = count_q + CW'(push) - CW'(pop);

      rx_cap    = bus.rx_valid && !rx_full_q;
      rx_clr    = sample && bus.ack && irr_q;
      rx_full_d = rx_full_q;
      if (rx_cap) rx_full_d = 1'b1;
      if (rx_clr) rx_full_d = 1'b0;
      rx_byte_d = rx_cap ? bus.rx_data : rx_byte_q;

      r_data_d  = '0;
      if (hit) begin
         case (offset)
            16'h0004: r_data_d = {24'b0, rx_byte_d};
`ifdef CPU_IO_STATUS_EN
            16'h0008: r_data_d = {29'b0, rx_full_d,
                                  (count_d == CW'(FIFO_DEPTH)), (count_d == '0)};
`endif
            default:  r_data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rx_full_q <= 1'b0;
         rx_byte_q <= '0;
         w_busy_q  <= 1'b0;
         irr_q     <= 1'b0;
         r_data_q  <= '0;
      end else begin
         phase_q   <= phase_d;
         count_q   <= count_d;
         rx_full_q <= rx_full_d;
         rx_byte_q <= rx_byte_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         // A pop between sample edges leaves w_busy set until the next sample edge.
         if (sample) begin
            w_busy_q <= (count_d == CW'(FIFO_DEPTH));
            irr_q    <= rx_full_d;
            r_data_q <= r_data_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.w_data[7:0];
   end

   assign bus.w_busy   = w_busy_q;
   assign bus.irr      = irr_q;
   assign bus.r_data   = r_data_q;
   assign bus.tx_valid = (count_q != '0) && !reset;
   assign bus.tx_data  = mem_q[rd_ptr_q];
   assign bus.rx_ready = !rx_full_q && !reset;
endmodule

// File: tb/tb_cpu_io_responder.sv
// Scoreboard bench for cpu_io_responder: stimulus queues expectations, a negedge monitor compares.
module tb_cpu_io_responder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cpu_io_responder_if bus();

   cpu_io_responder #(.BASE_ADDR(16'hFFFF), .FIFO_DEPTH(4), .PERIOD(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic        busy;
      logic        irr;
      logic [31:0] rdata;
   } cpu_exp_t;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } dir_exp_t;

   localparam int S_BUSY = 0, S_IRR = 1, S_RDATA = 2, S_TXV = 3, S_RXR = 4, S_TXQ = 5, S_CPUQ = 6;

`ifdef CPU_IO_STATUS_EN
   localparam logic [31:0] STATUS_EXP = 32'h0000_0006;
`else
   localparam logic [31:0] STATUS_EXP = 32'h0000_0000;
`endif

   logic [7:0] tx_q [$];
   cpu_exp_t   cpu_q [$];
   dir_exp_t   dir_q [$];

   int n_checks = 0;
   int n_fail   = 0;
   int ph;

   always @(posedge clk) begin
      if (reset) ph <= 0;
      else       ph <= (ph == 2) ? 0 : ph + 1;
   end

   function automatic logic [31:0] probe(input int sel);
      case (sel)
         S_BUSY:  return {31'b0, bus.w_busy};
         S_IRR:   return {31'b0, bus.irr};
         S_RDATA: return bus.r_data;
         S_TXV:   return {31'b0, bus.tx_valid};
         S_RXR:   return {31'b0, bus.rx_ready};
         S_TXQ:   return 32'(tx_q.size());
         default: return 32'(cpu_q.size());
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: sole owner of the counters; compares whatever the DUT presents.
   logic [7:0] tx_e;
   cpu_exp_t   cpu_e;
   dir_exp_t   dir_e;
   always @(negedge clk) begin
      if (!reset && bus.tx_valid && bus.tx_ready) begin
         if (tx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected_beat: got 0x%02h, expected no beat", bus.tx_data);
         end else begin
            tx_e = tx_q.pop_front();
            check("tx_beat", {24'b0, bus.tx_data}, {24'b0, tx_e});
         end
      end
      if (!reset && ph == 1 && cpu_q.size() > 0) begin
         cpu_e = cpu_q.pop_front();
         check({cpu_e.name, "_w_busy"}, {31'b0, bus.w_busy}, {31'b0, cpu_e.busy});
         check({cpu_e.name, "_irr"},    {31'b0, bus.irr},    {31'b0, cpu_e.irr});
         check({cpu_e.name, "_r_data"}, bus.r_data,          cpu_e.rdata);
      end
      while (dir_q.size() > 0) begin
         dir_e = dir_q.pop_front();
         check(dir_e.name, probe(dir_e.sel), dir_e.exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string name, input int sel, input logic [31:0] exp);
      dir_q.push_back('{name, sel, exp});
   endtask

   task automatic cpu_period(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                             input logic ak, input logic eb, input logic ei,
                             input logic [31:0] er, input string name);
      for (int i = 0; i < 3 && ph != 0; i++) tick();
      bus.addr   = a;
      bus.w_req  = wr;
      bus.w_data = wd;
      bus.ack    = ak;
      cpu_q.push_back('{name, eb, ei, er});
      repeat (3) tick();
      bus.w_req  = 1'b0;
      bus.ack    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      bus.addr     = '0;
      bus.w_req    = 1'b0;
      bus.w_data   = '0;
      bus.ack      = 1'b0;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;

      tick();
      expect_now("rst_w_busy",   S_BUSY,  0);
      expect_now("rst_irr",      S_IRR,   0);
      expect_now("rst_r_data",   S_RDATA, 0);
      expect_now("rst_tx_valid", S_TXV,   0);
      expect_now("rst_rx_ready", S_RXR,   0);
      tick();
      reset = 1'b0;
      expect_now("rx_ready_after_rst", S_RXR, 1);
      expect_now("tx_valid_after_rst", S_TXV, 0);
      cpu_period(32'h0, 0, 0, 0, 0, 0, 0, "idle1");
      cpu_period(32'h0, 0, 0, 0, 0, 0, 0, "idle2");

      // one store held for a full period yields one beat
      bus.tx_ready = 1'b1;
      tx_q.push_back(8'h41);
      cpu_period(32'hFFFF_0000, 1, 32'h1234_5641, 0, 0, 0, 0, "store_41");
      cpu_period(32'h0, 0, 0, 0, 0, 0, 0, "after_41");

      // fill with the stream stalled; fifth byte is dropped
      bus.tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) tx_q.push_back(8'(i));
         cpu_period(32'hFFFF_0000, 1, 32'(i), 0, (i >= 4), 0, 0, $sformatf("fill%0d", i));
      end
      bus.tx_ready = 1'b1;
      cpu_period(32'h0, 0, 0, 0, 0, 0, 0, "drain1");
      cpu_period(32'h0, 0, 0, 0, 0, 0, 0, "drain2");
      expect_now("tx_valid_empty", S_TXV, 0);

      // RX byte arrives mid-period
      tick();
      tick();
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hA5;
      tick();
      bus.rx_valid = 1'b0;
      expect_now("rx_ready_full", S_RXR, 0);
      cpu_period(32'hFFFF_0004, 0, 0, 0, 0, 1, 32'h0000_00A5, "rx_read_a5");
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hC3;
      cpu_period(32'hFFFF_0004, 0, 0, 1, 0, 0, 32'h0000_00A5, "ack_clear");
      bus.rx_valid = 1'b0;
      cpu_period(32'hFFFF_0004, 0, 0, 0, 0, 1, 32'h0000_00C3, "rx_read_c3");

      // stores outside the TX window must not push
      cpu_period(32'hFFFF_0004, 1, 32'h99, 0, 0, 1, 32'h0000_00C3, "wr_rx_offset");
      cpu_period(32'h1234_0000, 1, 32'h55, 0, 0, 1, 0, "wr_miss");
      cpu_period(32'hFFFF_0010, 0, 0, 0, 0, 1, 0, "rd_unmapped");

      // status with FIFO full and RX pending
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tx_q.push_back(8'(8'h10 + i));
         cpu_period(32'hFFFF_0000, 1, 32'(8'h10 + i), 0, (i == 3), 1, 0, $sformatf("full%0d", i));
      end
      cpu_period(32'hFFFF_0008, 0, 0, 0, 1, 1, STATUS_EXP, "status_read");
      bus.tx_ready = 1'b1;
      cpu_period(32'h0, 0, 0, 0, 0, 1, 0, "drain3");
      cpu_period(32'h0, 0, 0, 0, 0, 1, 0, "drain4");

      // mid-period reset with two queued bytes and RX pending
      bus.tx_ready = 1'b0;
      cpu_period(32'hFFFF_0000, 1, 32'h77, 0, 0, 1, 0, "pre_rst_a");
      cpu_period(32'hFFFF_0000, 1, 32'h88, 0, 0, 1, 0, "pre_rst_b");
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.tx_ready = 1'b1;
      expect_now("post_rst_tx_valid", S_TXV, 0);
      expect_now("post_rst_rx_ready", S_RXR, 1);
      expect_now("post_rst_irr",      S_IRR, 0);
      cpu_period(32'h0, 0, 0, 0, 0, 0, 0, "post_rst1");
      cpu_period(32'h0, 0, 0, 0, 0, 0, 0, "post_rst2");

      expect_now("tx_queue_drained",  S_TXQ,  0);
      expect_now("cpu_queue_drained", S_CPUQ, 0);
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
